// File: rtl/score_keeper.sv
// score_keeper: current and session-high 3-digit BCD scores for the snake game.
// Counts rising edges of Eat (bonus-qualified), saturates at a BCD ceiling,
// tracks the high score one cycle behind the current score, and registers the
// selected score onto three BCD digit outputs for the display multiplexer.
module score_keeper #(
  parameter int unsigned BONUS_VALUE        = 5,
  parameter int unsigned MAX_SCORE_HUNDREDS = 9
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       GameReset,
  input  logic       Eat,
  input  logic       Bonus,
  input  logic       ShowHigh,
  output logic [3:0] HundredsDigit,
  output logic [3:0] TensDigit,
  output logic [3:0] OnesDigit,
  output logic       NewHigh,
  output logic       Saturated
);

  localparam logic [3:0]  BonusAmt = 4'(BONUS_VALUE);
  localparam logic [3:0]  MaxHund  = 4'(MAX_SCORE_HUNDREDS);
  localparam logic [11:0] Ceiling  = {MaxHund, 4'd9, 4'd9};

  // Scores are packed {hundreds, tens, ones}, each a BCD nibble.
  logic [11:0] score_q, score_d;
  logic [11:0] high_q, high_d;
  logic [11:0] disp_q, disp_d;
  logic        eat_prev_q, eat_prev_d;
  logic        new_high_q, new_high_d;
  logic        saturated_q, saturated_d;

  logic        eat_evt;
  logic [3:0]  add_amt;
  logic [4:0]  ones_sum;
  logic [4:0]  tens_sum;
  logic [4:0]  hund_sum;
  logic [3:0]  ones_new;
  logic [3:0]  tens_new;
  logic        carry_ones;
  logic        carry_tens;
  logic        over_ceiling;
  logic [11:0] score_sum;
  logic        score_gt_high;

  // Lexicographic BCD compare, most significant digit first.
  function automatic logic bcd_gt(input logic [11:0] a, input logic [11:0] b);
    logic gt;
    if (a[11:8] != b[11:8]) begin
      gt = (a[11:8] > b[11:8]);
    end else if (a[7:4] != b[7:4]) begin
      gt = (a[7:4] > b[7:4]);
    end else begin
      gt = (a[3:0] > b[3:0]);
    end
    return gt;
  endfunction

  // Rising-edge detect on Eat and selection of the add amount.
  always_comb begin
    eat_evt = Eat & ~eat_prev_q;
    add_amt = Bonus ? BonusAmt : 4'd1;
  end

  // Ripple BCD adder with saturation at the ceiling.
  always_comb begin
    ones_sum   = {1'b0, score_q[3:0]} + {1'b0, add_amt};
    carry_ones = 1'b0;
    ones_new   = ones_sum[3:0];
    if (ones_sum > 5'd9) begin
      ones_new   = 4'(ones_sum - 5'd10);
      carry_ones = 1'b1;
    end

    tens_sum   = {1'b0, score_q[7:4]} + {4'b0000, carry_ones};
    carry_tens = 1'b0;
    tens_new   = tens_sum[3:0];
    if (tens_sum > 5'd9) begin
      tens_new   = 4'd0;
      carry_tens = 1'b1;
    end

    hund_sum = {1'b0, score_q[11:8]} + {4'b0000, carry_tens};
    // Tens/ones can never exceed 99, so overflow is decided by hundreds alone.
    over_ceiling = (hund_sum > {1'b0, MaxHund});
    score_sum    = over_ceiling ? Ceiling : {hund_sum[3:0], tens_new, ones_new};
  end

  // High-score comparison uses registered values, so high lags score by a cycle.
  always_comb begin
    score_gt_high = bcd_gt(score_q, high_q);
  end

  // Next-state: score, high score, flags and display selection.
  always_comb begin
    eat_prev_d  = Eat;
    score_d     = score_q;
    high_d      = high_q;
    new_high_d  = new_high_q;
    saturated_d = saturated_q;
    disp_d      = ShowHigh ? high_q : score_q;

    if (GameReset) begin
      // New round: drop any coincident Eat edge, keep the high score.
      score_d     = 12'h000;
      new_high_d  = 1'b0;
      saturated_d = 1'b0;
    end else begin
      if (eat_evt) begin
        score_d     = score_sum;
        saturated_d = (score_sum == Ceiling);
      end
      if (score_gt_high) begin
        high_d     = score_q;
        new_high_d = 1'b1;
      end
    end
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      score_q     <= 12'h000;
      high_q      <= 12'h000;
      disp_q      <= 12'h000;
      eat_prev_q  <= 1'b0;
      new_high_q  <= 1'b0;
      saturated_q <= 1'b0;
    end else begin
      score_q     <= score_d;
      high_q      <= high_d;
      disp_q      <= disp_d;
      eat_prev_q  <= eat_prev_d;
      new_high_q  <= new_high_d;
      saturated_q <= saturated_d;
    end
  end

  // Output mapping.
  always_comb begin
    HundredsDigit = disp_q[11:8];
    TensDigit     = disp_q[7:4];
    OnesDigit     = disp_q[3:0];
    NewHigh       = new_high_q;
    Saturated     = saturated_q;
  end

endmodule

// File: tb/tb_score_keeper.sv
// Directed bench for score_keeper with hand-computed expected digits and flags.
module tb_score_keeper;

  logic       Clock;
  logic       Reset;
  logic       GameReset;
  logic       Eat;
  logic       Bonus;
  logic       ShowHigh;
  logic [3:0] HundredsDigit;
  logic [3:0] TensDigit;
  logic [3:0] OnesDigit;
  logic       NewHigh;
  logic       Saturated;

  int n_cmp;
  int n_bad;

  score_keeper #(
    .BONUS_VALUE       (5),
    .MAX_SCORE_HUNDREDS(9)
  ) dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .GameReset    (GameReset),
    .Eat          (Eat),
    .Bonus        (Bonus),
    .ShowHigh     (ShowHigh),
    .HundredsDigit(HundredsDigit),
    .TensDigit    (TensDigit),
    .OnesDigit    (OnesDigit),
    .NewHigh      (NewHigh),
    .Saturated    (Saturated)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic check_digits(input string tag, input logic [11:0] exp);
    logic [11:0] obs;
    obs = {HundredsDigit, TensDigit, OnesDigit};
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %03h expected %03h", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // One isolated Eat pulse: high for one cycle, low for one cycle.
  task automatic eat(input logic b);
    Eat   = 1'b1;
    Bonus = b;
    tick();
    Eat   = 1'b0;
    Bonus = 1'b0;
    tick();
  endtask

  task automatic game_reset();
    GameReset = 1'b1;
    tick();
    GameReset = 1'b0;
  endtask

  initial begin
    n_cmp     = 0;
    n_bad     = 0;
    Reset     = 1'b1;
    GameReset = 1'b0;
    Eat       = 1'b0;
    Bonus     = 1'b0;
    ShowHigh  = 1'b0;

    // Reset state
    #12;
    check_digits("reset_digits", 12'h000);
    check_bit("reset_newhigh", NewHigh, 1'b0);
    check_bit("reset_sat", Saturated, 1'b0);
    #3;
    Reset = 1'b0;
    tick();

    // Three plain pulses; high trails score by one cycle
    Eat = 1'b1;
    tick();
    check_bit("newhigh_not_yet", NewHigh, 1'b0);
    Eat = 1'b0;
    tick();
    check_bit("newhigh_set", NewHigh, 1'b1);
    check_digits("score_001", 12'h001);
    eat(1'b0);
    eat(1'b0);
    check_digits("score_003", 12'h003);
    ShowHigh = 1'b1;
    tick();
    check_digits("high_003", 12'h003);
    ShowHigh = 1'b0;
    tick();

    // Eat held high counts once
    game_reset();
    Eat = 1'b1;
    repeat (10) tick();
    Eat = 1'b0;
    tick();
    check_digits("held_eat_001", 12'h001);

    // 098 + bonus 5 -> 103 with double carry
    game_reset();
    repeat (19) eat(1'b1);
    repeat (3) eat(1'b0);
    check_digits("score_098", 12'h098);
    eat(1'b1);
    check_digits("score_103", 12'h103);
    check_bit("sat_103", Saturated, 1'b0);
    check_bit("newhigh_103", NewHigh, 1'b1);

    // Saturation at 999
    game_reset();
    tick();
    check_bit("newhigh_cleared", NewHigh, 1'b0);
    repeat (199) eat(1'b1);
    repeat (2) eat(1'b0);
    check_digits("score_997", 12'h997);
    check_bit("sat_997", Saturated, 1'b0);
    eat(1'b1);
    check_digits("score_999", 12'h999);
    check_bit("sat_999", Saturated, 1'b1);
    eat(1'b1);
    check_digits("score_999_hold", 12'h999);
    check_bit("sat_999_hold", Saturated, 1'b1);
    ShowHigh = 1'b1;
    tick();
    check_digits("high_999", 12'h999);
    ShowHigh = 1'b0;
    tick();

    // Asynchronous reset between clock edges
    Eat = 1'b1;
    tick();
    #2;
    Reset = 1'b1;
    #1;
    check_digits("async_rst_digits", 12'h000);
    check_bit("async_rst_newhigh", NewHigh, 1'b0);
    check_bit("async_rst_sat", Saturated, 1'b0);
    Eat      = 1'b0;
    ShowHigh = 1'b1;
    #1;
    check_digits("async_rst_high", 12'h000);
    ShowHigh = 1'b0;
    Reset    = 1'b0;
    tick();

    // Build 012; first edge after reset counts normally
    eat(1'b1);
    eat(1'b1);
    eat(1'b0);
    eat(1'b0);
    check_digits("score_012", 12'h012);
    ShowHigh = 1'b1;
    tick();
    check_digits("high_012", 12'h012);
    ShowHigh = 1'b0;
    tick();
    check_bit("newhigh_012", NewHigh, 1'b1);

    // GameReset discards a coincident Eat edge; EatPrev still tracks Eat
    GameReset = 1'b1;
    Eat       = 1'b1;
    tick();
    check_bit("gr_newhigh", NewHigh, 1'b0);
    GameReset = 1'b0;
    tick();
    Eat = 1'b0;
    tick();
    check_digits("gr_score_000", 12'h000);
    ShowHigh = 1'b1;
    tick();
    check_digits("gr_high_012", 12'h012);
    ShowHigh = 1'b0;
    tick();
    check_digits("gr_back_000", 12'h000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
